// File: rtl/axi_aw_pkg.sv
// AXI write-address channel definitions shared by the AW FIFO slice.
// Field widths, packed-payload offsets above the user field, response codes.
package axi_aw_pkg;

  localparam int LEN_W    = 8;
  localparam int SIZE_W   = 3;
  localparam int BURST_W  = 2;
  localparam int LOCK_W   = 1;
  localparam int CACHE_W  = 4;
  localparam int PROT_W   = 3;
  localparam int QOS_W    = 4;
  localparam int REGION_W = 4;

  // Fixed (non-parameterised) field bits in one AW beat.
  localparam int AW_FIX_W = LEN_W + SIZE_W + BURST_W + LOCK_W
                          + CACHE_W + PROT_W + QOS_W + REGION_W;

  // Offsets of fixed fields, counted from the top of the user field.
  localparam int REGION_OFF = 0;
  localparam int QOS_OFF    = REGION_OFF + REGION_W;
  localparam int PROT_OFF   = QOS_OFF + QOS_W;
  localparam int CACHE_OFF  = PROT_OFF + PROT_W;
  localparam int LOCK_OFF   = CACHE_OFF + CACHE_W;
  localparam int BURST_OFF  = LOCK_OFF + LOCK_W;
  localparam int SIZE_OFF   = BURST_OFF + BURST_W;
  localparam int LEN_OFF    = SIZE_OFF + SIZE_W;
  localparam int ADDR_OFF   = LEN_OFF + LEN_W;

  function automatic int aw_w(input int addr_w, input int id_w,
                              input int user_w);
    return addr_w + id_w + user_w + AW_FIX_W;
  endfunction

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

endpackage

// File: rtl/slave_aw_fifo_if.sv
// Valid/ready AW handshake bundle with producer and consumer views.
// Signals: valid, ready, aw payload (AW_W bits).
interface slave_aw_fifo_if #(
  parameter int AW_W = 87
) ();
  logic            valid;
  logic            ready;
  logic [AW_W-1:0] aw;

  modport master (output valid, output aw, input ready);
  modport slave  (input valid, input aw, output ready);
endinterface

// File: rtl/aw_fifo_mem.sv
// AW FIFO storage: DEPTH x WIDTH register array, no reset.
// Ports: clk_i, we_i/waddr_i/wdata_i write, raddr_i/rdata_o async read.
module aw_fifo_mem #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 87,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [PTR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [PTR_W-1:0] raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/slave_aw_fifo.sv
// AXI AW channel FIFO with optional empty-bypass (fall-through) output.
// Ports: upstream slave_*, downstream master_*, count_o/full_o/empty_o.
module slave_aw_fifo
  import axi_aw_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int ID_WIDTH      = 16,
  parameter int USER_WIDTH    = 10,
  parameter int BUFF_DEPTH    = 4,
  parameter int FALL_THROUGH  = 0,
  localparam int AW_W  = aw_w(ADDRESS_WIDTH, ID_WIDTH, USER_WIDTH),
  localparam int CNT_W = $clog2(BUFF_DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             test_en_i,
  input  logic             slave_valid_i,
  input  logic [AW_W-1:0]  slave_aw_i,
  output logic             slave_ready_o,
  output logic             master_valid_o,
  output logic [AW_W-1:0]  master_aw_o,
  input  logic             master_ready_i,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(BUFF_DEPTH);

  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AW_W-1:0]  rdata;
  logic bypass, push, pop, wr_en, rd_en;
  logic unused_test_en;

  assign unused_test_en = test_en_i;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_W'(BUFF_DEPTH));
  assign count_o = cnt_q;

  // Bypass only applies while storage is empty.
  assign bypass = (FALL_THROUGH != 0) && empty_o;

  assign slave_ready_o  = rst_ni && !full_o;
  assign master_valid_o = rst_ni && (bypass ? slave_valid_i : !empty_o);

  always_comb begin
    master_aw_o = '0;
    if (master_valid_o) master_aw_o = bypass ? slave_aw_i : rdata;
  end

  assign push = slave_valid_i && slave_ready_o;
  assign pop  = master_valid_o && master_ready_i;

  // A bypassed beat that is taken the same cycle never touches storage.
  assign wr_en = push && !(bypass && pop);
  assign rd_en = pop && !bypass;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (wr_en) wptr_d = wptr_q + PTR_W'(1);
    if (rd_en) rptr_d = rptr_q + PTR_W'(1);
    unique case ({wr_en, rd_en})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  aw_fifo_mem #(
    .DEPTH (BUFF_DEPTH),
    .WIDTH (AW_W)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (wr_en),
    .waddr_i (wptr_q),
    .wdata_i (slave_aw_i),
    .raddr_i (rptr_q),
    .rdata_o (rdata)
  );

endmodule

// File: tb/tb_slave_aw_fifo.sv
// Bench for slave_aw_fifo: both output modes driven in lockstep,
// each checked against a queue model of the FIFO.
module tb_slave_aw_fifo;
  import axi_aw_pkg::*;

  localparam int AW = 87;
  localparam int D  = 4;
  typedef logic [AW-1:0] aw_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sv = 1'b0;
  logic mr = 1'b0;
  aw_t  saw = '0;
  logic [2:0] cnt0, cnt1;
  logic full0, full1, emp0, emp1;

  int n_chk = 0;
  int n_err = 0;
  aw_t q0[$];
  aw_t q1[$];

  always #5 clk = ~clk;

  slave_aw_fifo_if #(.AW_W(AW)) up0 ();
  slave_aw_fifo_if #(.AW_W(AW)) up1 ();
  slave_aw_fifo_if #(.AW_W(AW)) dn0 ();
  slave_aw_fifo_if #(.AW_W(AW)) dn1 ();

  assign up0.valid = sv;
  assign up1.valid = sv;
  assign up0.aw = saw;
  assign up1.aw = saw;
  assign dn0.ready = mr;
  assign dn1.ready = mr;

  slave_aw_fifo #(.FALL_THROUGH(0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .test_en_i(1'b0),
    .slave_valid_i(up0.valid), .slave_aw_i(up0.aw),
    .slave_ready_o(up0.ready),
    .master_valid_o(dn0.valid), .master_aw_o(dn0.aw),
    .master_ready_i(dn0.ready),
    .count_o(cnt0), .full_o(full0), .empty_o(emp0)
  );

  slave_aw_fifo #(.FALL_THROUGH(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .test_en_i(1'b0),
    .slave_valid_i(up1.valid), .slave_aw_i(up1.aw),
    .slave_ready_o(up1.ready),
    .master_valid_o(dn1.valid), .master_aw_o(dn1.aw),
    .master_ready_i(dn1.ready),
    .count_o(cnt1), .full_o(full1), .empty_o(emp1)
  );

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic aw_t mk(input logic [15:0] id, input logic [31:0] a);
    logic [28:0] mid;
    logic [9:0] usr;
    mid = 29'($urandom);
    usr = 10'($urandom);
    return {id, a, mid, usr};
  endfunction

  // Expected behaviour from a FIFO-of-beats view of the block.
  task automatic model(input bit ft, input logic mv, input aw_t maw,
                       input logic sr, input logic [2:0] cnt,
                       input logic full, input logic emp);
    aw_t q[$];
    bit er, ev, byp, push, pop;
    aw_t eaw;
    string p;
    p = ft ? "ft1" : "ft0";
    if (ft) q = q1; else q = q0;
    chk({p, ".count"}, cnt, q.size());
    chk({p, ".full"}, full, q.size() == D);
    chk({p, ".empty"}, emp, q.size() == 0);
    if (!rst_n) begin
      chk({p, ".rst_ready"}, sr, 0);
      chk({p, ".rst_valid"}, mv, 0);
      chk({p, ".rst_aw"}, maw, 0);
      q.delete();
    end else begin
      er  = q.size() < D;
      byp = ft && q.size() == 0;
      ev  = byp ? sv : (q.size() > 0);
      eaw = '0;
      if (ev) eaw = byp ? saw : q[0];
      chk({p, ".ready"}, sr, er);
      chk({p, ".valid"}, mv, ev);
      chk({p, ".aw"}, maw, eaw);
      push = sv && er;
      pop  = ev && mr;
      if (byp) begin
        if (push && !pop) q.push_back(saw);
      end else begin
        if (pop) void'(q.pop_front());
        if (push) q.push_back(saw);
      end
    end
    if (ft) q1 = q; else q0 = q;
  endtask

  task automatic tick();
    @(negedge clk);
    model(0, dn0.valid, dn0.aw, up0.ready, cnt0, full0, emp0);
    model(1, dn1.valid, dn1.aw, up1.ready, cnt1, full1, emp1);
    @(posedge clk);
    #1;
  endtask

  aw_t hold;

  initial begin
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("post_rst_cnt", cnt0, 0);
    chk("post_rst_ready", up0.ready, 1);

    mr = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      sv = 1'b1;
      saw = mk(16'(i), 32'(i * 16));
      tick();
    end
    chk("fill_full", full0, 1);
    chk("fill_cnt", cnt0, 4);
    chk("fill_ready", up0.ready, 0);
    saw = mk(16'h99, 32'h50);
    tick();
    chk("ovf_cnt", cnt0, 4);

    sv = 1'b0;
    mr = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_addr", dn0.aw[70:39], 32'(i * 16));
      tick();
    end
    chk("drain_empty", emp0, 1);
    chk("drain_empty1", emp1, 1);

    for (int i = 0; i < 10; i++) begin
      sv = 1'b1;
      saw = mk(16'(i), 32'($urandom));
      tick();
      chk("stream_cnt", cnt0, 1);
    end
    sv = 1'b0;
    tick();

    sv = 1'b1;
    mr = 1'b1;
    saw = mk(16'h5, 32'h1234);
    #1;
    chk("ft_valid", dn1.valid, 1);
    chk("ft_id", dn1.aw[86:71], 16'h5);
    tick();
    chk("ft_cnt", cnt1, 0);
    sv = 1'b0;
    tick();

    mr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sv = 1'b1;
      saw = mk(16'(i), 32'($urandom));
      tick();
    end
    sv = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    chk("rst_cnt", cnt0, 0);
    chk("rst_valid", dn0.valid, 0);
    chk("rst_aw", dn0.aw, 0);
    chk("rst_ready", up0.ready, 1);

    sv = 1'b1;
    hold = mk(16'hab, 32'hcafe);
    saw = hold;
    tick();
    sv = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", dn0.valid, 1);
      chk("stall_aw", dn0.aw, hold);
      tick();
    end
    mr = 1'b1;
    tick();

    for (int i = 0; i < 400; i++) begin
      sv = 1'($urandom_range(0, 1));
      mr = ($urandom_range(0, 3) != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      saw = mk(16'($urandom), 32'($urandom));
      rst_n = ($urandom_range(0, 60) != 0);
      tick();
    end
    rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/slave_aw_fifo.md
SLAVE_AW_FIFO -- requirements
Module: slave_aw_fifo

Interface
REQ-001 Parameters SHALL be:
- ADDRESS_WIDTH, default 32: AW address width.
- ID_WIDTH, default 16: AW ID width.
- USER_WIDTH, default 10: AW user width.
- BUFF_DEPTH, default 4: entry count; power of two, >=2.
- FALL_THROUGH, default 0: 0 = registered output, 1 = empty-bypass output.
REQ-002 Derived widths SHALL be AW_W = ADDRESS_WIDTH+ID_WIDTH+USER_WIDTH+29 and CNT_W = clog2(BUFF_DEPTH)+1.
REQ-003 Ports SHALL be (name, direction, width, meaning):
- clk_i  in  1  sole clock; all state on rising edge.
- rst_ni  in  1  reset; synchronous, active-low.
- test_en_i  in  1  reserved; no functional effect.
- slave_valid_i  in  1  upstream AW valid.
- slave_aw_i  in  AW_W  packed AW payload.
- slave_ready_o  out  1  upstream AW ready.
- master_valid_o  out  1  downstream AW valid.
- master_aw_o  out  AW_W  packed AW payload.
- master_ready_i  in  1  downstream AW ready.
- count_o  out  CNT_W  stored-entry count.
- full_o  out  1  count_o == BUFF_DEPTH.
- empty_o  out  1  count_o == 0.
REQ-004 Payload packing, MSB to LSB, SHALL be: id, addr, len[7:0], size[2:0], burst[1:0], lock, cache[3:0], prot[2:0], qos[3:0], region[3:0], user.

Function
REQ-005 Push SHALL occur when slave_valid_i && slave_ready_o; pop SHALL occur when master_valid_o && master_ready_i.
REQ-006 slave_ready_o SHALL equal !full_o and SHALL NOT depend combinationally on master_ready_i; when full, a same-cycle pop does not enable a push.
REQ-007 If FALL_THROUGH=0: master_valid_o SHALL equal !empty_o, and master_aw_o SHALL be the oldest entry. A push is visible on master one cycle later.
REQ-008 If FALL_THROUGH=1 and the FIFO is empty: master_valid_o SHALL equal slave_valid_i, and master_aw_o SHALL equal slave_aw_i (zero-cycle latency). A same-cycle push and pop SHALL bypass storage and leave count unchanged.
REQ-009 Push and pop in the same cycle on a non-empty FIFO SHALL advance both pointers and leave count_o unchanged.
REQ-010 Read and write pointers SHALL wrap modulo BUFF_DEPTH; entries SHALL pop in strict push order.
REQ-011 Once master_valid_o is high, master_valid_o and master_aw_o SHALL stay stable until the pop, per AXI.
REQ-012 master_aw_o SHALL drive all-zero whenever master_valid_o is low.
REQ-013 count_o, full_o and empty_o SHALL be registered state and SHALL update on the edge following a push or pop.
REQ-014 A pop request while empty, or a push request while full, SHALL have no effect.

Reset
REQ-015 While rst_ni is low at a rising edge, the block SHALL clear pointers and count. Next-cycle outputs SHALL be: count_o=0, empty_o=1, full_o=0, master_valid_o=0, master_aw_o=0, slave_ready_o=1.
REQ-016 While rst_ni is low, slave_ready_o and master_valid_o SHALL be forced 0 combinationally in both modes.
REQ-017 Reset mid-operation SHALL discard all stored entries. Storage contents SHALL NOT require reset.

Structure
REQ-018 Package axi_aw_pkg SHALL hold:
- AW field widths and the AW_W formula.
- Field offsets for REQ-004.
- Response codes OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
REQ-019 Storage SHALL be one sub-module, aw_fifo_mem:
- BUFF_DEPTH x AW_W register array.
- One write port; one asynchronous read port.
- Pointers, count and handshake logic stay in slave_aw_fifo.

Verification (BUFF_DEPTH=4)
REQ-020 FT=0, master_ready_i=0; push addr 0x10,0x20,0x30,0x40.
- After the 4th push: full_o=1, count_o=4, slave_ready_o=0.
- A 5th push with slave_valid_i=1 is ignored.
REQ-021 From full, raise master_ready_i.
- Pops SHALL present 0x10,0x20,0x30,0x40 in order; then empty_o=1.
REQ-022 Continuous push and pop, 10 beats, ids 0..9.
- count_o SHALL hold at 1 throughout; output ids 0..9 in order.
- Pointers wrap twice.
REQ-023 FT=1, empty, push id 0x5 with master_ready_i=1.
- master_valid_o=1 and master_aw_o id=0x5 in the same cycle; count_o stays 0.
REQ-024 Hold 3 entries, assert rst_ni=0 for one cycle.
- Next cycle: count_o=0, master_valid_o=0, master_aw_o=0, slave_ready_o=1.
REQ-025 Stall master_ready_i=0 for 5 cycles with 1 entry.
- master_aw_o and master_valid_o SHALL stay constant every cycle.
